// File: rtl/fx2_emu_pkg.sv
// ============================================================================
// Module      : fx2_emu_pkg
// Description : Shared FIFOADR codes and FSM encodings for the FX2 slave-FIFO
//               chip-side emulation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fx2_emu_pkg;

    localparam logic [1:0] EP2_ADDR = 2'b00;
    localparam logic [1:0] EP6_ADDR = 2'b10;

    typedef enum logic [1:0] {
        P_EMPTY = 2'b01,
        P_OPEN  = 2'b10
    } asm_state_t;

    typedef enum logic [1:0] {
        D_IDLE  = 2'b01,
        D_BURST = 2'b10
    } drn_state_t;

endpackage

`default_nettype wire

// File: rtl/fx2_sync_fifo.sv
// ============================================================================
// Module      : fx2_sync_fifo
// Description : Single-clock first-word fall-through FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fx2_sync_fifo
    import fx2_emu_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [W-1:0]             wr_data_i,
    input  logic                     rd_en_i,
    output logic [W-1:0]             rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          w_push, w_pop;

    assign w_push = wr_en_i && (cnt_q != FULL_CNT);
    assign w_pop  = rd_en_i && (cnt_q != '0);

    always_comb begin
        cnt_d = cnt_q;
        if (w_push && !w_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (w_pop && !w_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (w_push) wptr_q <= wptr_q + 1'b1;
            if (w_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage carries no reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_push) mem_q[wptr_q] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rptr_q];
    assign count_o   = cnt_q;

endmodule

`default_nettype wire

// File: rtl/fx2_slave_fifo_emu.sv
// ============================================================================
// Module      : fx2_slave_fifo_emu
// Description : FX2 chip-side slave-FIFO emulation: EP2 OUT fed by a host
//               stream, EP6 IN packets assembled and drained to the host.
//               Define FX2_EMU_ERR_EN to build the sticky error flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fx2_slave_fifo_emu
    import fx2_emu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int EP_DEPTH  = 512,
    parameter int PKT_SIZE  = 512,
    parameter int LEN_DEPTH = 4
) (
    input  logic              fx2_ifclk,
    input  logic              reset,
    input  logic [1:0]        fx2_faddr,
    input  logic              fx2_sloe,
    input  logic              fx2_slrd,
    input  logic              fx2_slwr,
    input  logic              fx2_pkt_end,
    input  logic [DATA_W-1:0] fx2_fdata_i,
    output logic [DATA_W-1:0] fx2_fdata_o,
    output logic              fx2_flagb,
    output logic              fx2_flagc,
    input  logic [DATA_W-1:0] host_out_data,
    input  logic              host_out_valid,
    output logic              host_out_ready,
    output logic [DATA_W-1:0] host_in_data,
    output logic              host_in_valid,
    output logic              host_in_last,
    input  logic              host_in_ready,
    output logic              err_underrun,
    output logic              err_overrun
);

    localparam int               EP_AW   = $clog2(EP_DEPTH);
    localparam int               LQ_AW   = $clog2(LEN_DEPTH);
    localparam int               LEN_W   = $clog2(PKT_SIZE + 1);
    localparam logic [EP_AW:0]   EP_FULL = (EP_AW+1)'(EP_DEPTH);
    localparam logic [LQ_AW:0]   LQ_FULL = (LQ_AW+1)'(LEN_DEPTH);
    localparam logic [LEN_W-1:0] PKT_LEN = LEN_W'(PKT_SIZE);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    logic              w_ep2_sel, w_ep6_sel, w_rd_req, w_wr_req, w_pkt_end_req;
    logic              w_ep2_push, w_ep2_pop, w_ep6_push, w_ep6_pop;
    logic              w_len_push, w_len_pop, w_len_full, w_ep2_empty;
    logic [DATA_W-1:0] w_ep2_head, w_ep6_head;
    logic [EP_AW:0]    w_ep2_count, w_ep6_count;
    logic [LQ_AW:0]    w_len_count;
    logic [LEN_W-1:0]  w_len_head, w_cnt_inc;

    asm_state_t        asm_q, asm_d;
    drn_state_t        drn_q, drn_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  rem_q, rem_d;

    assign w_ep2_sel     = (fx2_faddr == EP2_ADDR);
    assign w_ep6_sel     = (fx2_faddr == EP6_ADDR);
    assign w_rd_req      = !fx2_slrd && w_ep2_sel;
    assign w_wr_req      = !fx2_slwr && w_ep6_sel;
    assign w_pkt_end_req = !fx2_pkt_end && w_ep6_sel;

    assign w_ep2_empty    = (w_ep2_count == '0);
    assign w_len_full     = (w_len_count == LQ_FULL);
    assign fx2_flagb      = !w_ep2_empty;
    assign fx2_flagc      = (w_ep6_count < EP_FULL) && !w_len_full;
    assign host_out_ready = (w_ep2_count != EP_FULL);

    assign w_ep2_push  = host_out_valid && host_out_ready;
    assign w_ep2_pop   = w_rd_req && !w_ep2_empty;
    assign w_ep6_push  = w_wr_req && fx2_flagc;
    assign fx2_fdata_o = (!fx2_sloe && w_ep2_sel && !w_ep2_empty) ? w_ep2_head : '0;
    assign host_in_data = w_ep6_head;
    assign w_cnt_inc   = cnt_q + LEN_W'(w_ep6_push);

    fx2_sync_fifo #(.W(DATA_W), .DEPTH(EP_DEPTH)) u_ep2 (
        .clk       (fx2_ifclk),
        .rst       (reset),
        .wr_en_i   (w_ep2_push),
        .wr_data_i (host_out_data),
        .rd_en_i   (w_ep2_pop),
        .rd_data_o (w_ep2_head),
        .count_o   (w_ep2_count)
    );

    fx2_sync_fifo #(.W(DATA_W), .DEPTH(EP_DEPTH)) u_ep6 (
        .clk       (fx2_ifclk),
        .rst       (reset),
        .wr_en_i   (w_ep6_push),
        .wr_data_i (fx2_fdata_i),
        .rd_en_i   (w_ep6_pop),
        .rd_data_o (w_ep6_head),
        .count_o   (w_ep6_count)
    );

    fx2_sync_fifo #(.W(LEN_W), .DEPTH(LEN_DEPTH)) u_len (
        .clk       (fx2_ifclk),
        .rst       (reset),
        .wr_en_i   (w_len_push),
        .wr_data_i (w_cnt_inc),
        .rd_en_i   (w_len_pop),
        .rd_data_o (w_len_head),
        .count_o   (w_len_count)
    );

    // A bare pkt_end while the length queue is full leaves the packet open
    // rather than losing its length; a later pkt_end commits it.
    always_comb begin
        asm_d      = asm_q;
        cnt_d      = cnt_q;
        w_len_push = 1'b0;
        if ((w_ep6_push && (w_cnt_inc == PKT_LEN)) ||
            (w_pkt_end_req && (w_cnt_inc != '0) && !w_len_full)) begin
            w_len_push = 1'b1;
            cnt_d      = '0;
            asm_d      = P_EMPTY;
        end else if (w_ep6_push) begin
            cnt_d = w_cnt_inc;
            asm_d = P_OPEN;
        end
    end

    always_comb begin
        drn_d         = drn_q;
        rem_d         = rem_q;
        w_len_pop     = 1'b0;
        w_ep6_pop     = 1'b0;
        host_in_valid = 1'b0;
        host_in_last  = 1'b0;
        case (drn_q)
            D_IDLE: begin
                if (w_len_count != '0) begin
                    w_len_pop = 1'b1;
                    rem_d     = w_len_head;
                    drn_d     = D_BURST;
                end
            end
            D_BURST: begin
                host_in_valid = 1'b1;
                host_in_last  = (rem_q == LEN_ONE);
                if (host_in_ready) begin
                    w_ep6_pop = 1'b1;
                    rem_d     = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) drn_d = D_IDLE;
                end
            end
            default: drn_d = D_IDLE;
        endcase
    end

    always_ff @(posedge fx2_ifclk or posedge reset) begin
        if (reset) begin
            asm_q <= P_EMPTY;
            cnt_q <= '0;
            drn_q <= D_IDLE;
            rem_q <= '0;
        end else begin
            asm_q <= asm_d;
            cnt_q <= cnt_d;
            drn_q <= drn_d;
            rem_q <= rem_d;
        end
    end

`ifdef FX2_EMU_ERR_EN
    logic err_under_q, err_over_q;

    always_ff @(posedge fx2_ifclk or posedge reset) begin
        if (reset) begin
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            if (w_rd_req && w_ep2_empty) err_under_q <= 1'b1;
            if (w_wr_req && !fx2_flagc)  err_over_q  <= 1'b1;
        end
    end

    assign err_underrun = err_under_q;
    assign err_overrun  = err_over_q;
`else
    assign err_underrun = 1'b0;
    assign err_overrun  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fx2_slave_fifo_emu.sv
// ============================================================================
// Module      : tb_fx2_slave_fifo_emu
// Description : Directed bench for fx2_slave_fifo_emu (two parameterisations
//               sharing one stimulus: 16-byte and 4-byte auto-commit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fx2_slave_fifo_emu;

`ifdef FX2_EMU_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] faddr = 2'b01;
    logic       sloe = 1'b1, slrd = 1'b1, slwr = 1'b1, pkt_end = 1'b1;
    logic [7:0] wdata = '0, hod = '0;
    logic       hov = 1'b0, hir = 1'b1;

    logic [7:0] fdo_a, hid_a, fdo_b, hid_b;
    logic       flagb_a, flagc_a, hor_a, hiv_a, hil_a, eu_a, eo_a;
    logic       flagb_b, flagc_b, hor_b, hiv_b, hil_b, eu_b, eo_b;

    int n_chk = 0;
    int n_err = 0;
    int cyc_n = 0;

    logic [7:0] qa_d[$], qb_d[$];
    logic       qa_l[$], qb_l[$];
    int         qa_c[$], qb_c[$];

    typedef struct {
        logic [1:0] fa;
        logic       oe, rd, wr, pe;
        logic [7:0] wd;
        logic       hv;
        logic [7:0] hd;
        logic [7:0] e_fdo;
        logic       e_fb, e_fc, e_iv, e_il;
        logic [7:0] e_id;
    } vec_t;

    vec_t vq[$];

    fx2_slave_fifo_emu #(.DATA_W(8), .EP_DEPTH(16), .PKT_SIZE(16), .LEN_DEPTH(4)) u_dut (
        .fx2_ifclk(clk), .reset(rst), .fx2_faddr(faddr), .fx2_sloe(sloe),
        .fx2_slrd(slrd), .fx2_slwr(slwr), .fx2_pkt_end(pkt_end),
        .fx2_fdata_i(wdata), .fx2_fdata_o(fdo_a), .fx2_flagb(flagb_a), .fx2_flagc(flagc_a),
        .host_out_data(hod), .host_out_valid(hov), .host_out_ready(hor_a),
        .host_in_data(hid_a), .host_in_valid(hiv_a), .host_in_last(hil_a),
        .host_in_ready(hir), .err_underrun(eu_a), .err_overrun(eo_a)
    );

    fx2_slave_fifo_emu #(.DATA_W(8), .EP_DEPTH(16), .PKT_SIZE(4), .LEN_DEPTH(4)) u_dut4 (
        .fx2_ifclk(clk), .reset(rst), .fx2_faddr(faddr), .fx2_sloe(sloe),
        .fx2_slrd(slrd), .fx2_slwr(slwr), .fx2_pkt_end(pkt_end),
        .fx2_fdata_i(wdata), .fx2_fdata_o(fdo_b), .fx2_flagb(flagb_b), .fx2_flagc(flagc_b),
        .host_out_data(hod), .host_out_valid(hov), .host_out_ready(hor_b),
        .host_in_data(hid_b), .host_in_valid(hiv_b), .host_in_last(hil_b),
        .host_in_ready(hir), .err_underrun(eu_b), .err_overrun(eo_b)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [1:0] fa, input logic oe, rd, wr, pe,
                               input logic [7:0] wd, input logic hv, input logic [7:0] hd,
                               input logic [7:0] fdo, input logic fb, fc, iv, il,
                               input logic [7:0] id);
        vec_t r;
        r.fa = fa; r.oe = oe; r.rd = rd; r.wr = wr; r.pe = pe; r.wd = wd;
        r.hv = hv; r.hd = hd; r.e_fdo = fdo; r.e_fb = fb; r.e_fc = fc;
        r.e_iv = iv; r.e_il = il; r.e_id = id;
        return r;
    endfunction

    task automatic idle();
        faddr = 2'b01; sloe = 1'b1; slrd = 1'b1; slwr = 1'b1; pkt_end = 1'b1;
        wdata = '0; hov = 1'b0; hod = '0;
    endtask

    task automatic record();
        if (hiv_a && hir) begin qa_d.push_back(hid_a); qa_l.push_back(hil_a); qa_c.push_back(cyc_n); end
        if (hiv_b && hir) begin qb_d.push_back(hid_b); qb_l.push_back(hil_b); qb_c.push_back(cyc_n); end
        cyc_n++;
    endtask

    task automatic clear_q();
        qa_d.delete(); qa_l.delete(); qa_c.delete();
        qb_d.delete(); qb_l.delete(); qb_c.delete();
        cyc_n = 0;
    endtask

    // Inputs are driven at posedge+1; settle moves to posedge+2 for sampling.
    task automatic settle(); #1; endtask
    task automatic adv(); record(); @(posedge clk); #1; endtask
    task automatic step(); settle(); adv(); endtask

    task automatic wr(input logic [7:0] d, input logic pe);
        faddr = 2'b10; slwr = 1'b0; wdata = d; pkt_end = pe;
        step();
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        // EP2 host fill and controller read-out
        vq.push_back(v(2'b01,1,1,1,1,8'h00, 0,8'h00, 8'h00,0,1,0,0,8'h00));
        vq.push_back(v(2'b01,1,1,1,1,8'h00, 1,8'h11, 8'h00,0,1,0,0,8'h00));
        vq.push_back(v(2'b01,1,1,1,1,8'h00, 1,8'h22, 8'h00,1,1,0,0,8'h00));
        vq.push_back(v(2'b01,1,1,1,1,8'h00, 1,8'h33, 8'h00,1,1,0,0,8'h00));
        vq.push_back(v(2'b00,0,0,1,1,8'h00, 0,8'h00, 8'h11,1,1,0,0,8'h00));
        vq.push_back(v(2'b00,0,0,1,1,8'h00, 0,8'h00, 8'h22,1,1,0,0,8'h00));
        vq.push_back(v(2'b00,0,0,1,1,8'h00, 0,8'h00, 8'h33,1,1,0,0,8'h00));
        vq.push_back(v(2'b01,1,1,1,1,8'h00, 0,8'h00, 8'h00,0,1,0,0,8'h00));
        // EP6 five-byte packet closed by pkt_end on the last write
        for (int i = 0; i < 4; i++)
            vq.push_back(v(2'b10,1,1,0,1,8'hA0 + 8'(i), 0,8'h00, 8'h00,0,1,0,0,8'h00));
        vq.push_back(v(2'b10,1,1,0,0,8'hA4, 0,8'h00, 8'h00,0,1,0,0,8'h00));
        vq.push_back(v(2'b01,1,1,1,1,8'h00, 0,8'h00, 8'h00,0,1,0,0,8'h00));
        for (int i = 0; i < 5; i++)
            vq.push_back(v(2'b01,1,1,1,1,8'h00, 0,8'h00, 8'h00,0,1,1,(i == 4),8'hA0 + 8'(i)));
        vq.push_back(v(2'b01,1,1,1,1,8'h00, 0,8'h00, 8'h00,0,1,0,0,8'h00));
        // pkt_end with nothing open, then strobes at non-endpoint addresses
        vq.push_back(v(2'b10,1,1,1,0,8'h00, 0,8'h00, 8'h00,0,1,0,0,8'h00));
        vq.push_back(v(2'b10,1,1,1,0,8'h00, 0,8'h00, 8'h00,0,1,0,0,8'h00));
        vq.push_back(v(2'b01,1,1,1,1,8'h00, 0,8'h00, 8'h00,0,1,0,0,8'h00));
        vq.push_back(v(2'b01,1,0,0,1,8'hFF, 0,8'h00, 8'h00,0,1,0,0,8'h00));
        vq.push_back(v(2'b11,1,0,0,0,8'hFF, 0,8'h00, 8'h00,0,1,0,0,8'h00));
        vq.push_back(v(2'b01,1,1,1,1,8'h00, 0,8'h00, 8'h00,0,1,0,0,8'h00));
        vq.push_back(v(2'b01,1,1,1,1,8'h00, 0,8'h00, 8'h00,0,1,0,0,8'h00));

        do_reset();
        hir = 1'b1;
        for (int i = 0; i < vq.size(); i++) begin
            faddr = vq[i].fa; sloe = vq[i].oe; slrd = vq[i].rd; slwr = vq[i].wr;
            pkt_end = vq[i].pe; wdata = vq[i].wd; hov = vq[i].hv; hod = vq[i].hd;
            settle();
            chk($sformatf("v%0d fdata_o", i), 32'(fdo_a), 32'(vq[i].e_fdo));
            chk($sformatf("v%0d flagb", i), 32'(flagb_a), 32'(vq[i].e_fb));
            chk($sformatf("v%0d flagc", i), 32'(flagc_a), 32'(vq[i].e_fc));
            chk($sformatf("v%0d host_in_valid", i), 32'(hiv_a), 32'(vq[i].e_iv));
            chk($sformatf("v%0d host_in_last", i), 32'(hil_a), 32'(vq[i].e_il));
            if (vq[i].e_iv)
                chk($sformatf("v%0d host_in_data", i), 32'(hid_a), 32'(vq[i].e_id));
            chk($sformatf("v%0d host_out_ready", i), 32'(hor_a), 32'h1);
            chk($sformatf("v%0d err_underrun", i), 32'(eu_a), 32'h0);
            chk($sformatf("v%0d err_overrun", i), 32'(eo_a), 32'h0);
            @(posedge clk); #1;
        end
        idle();

        // Auto-commit at PKT_SIZE=4: eight writes become two packets
        do_reset();
        clear_q();
        hir = 1'b1;
        for (int i = 0; i < 8; i++) wr(8'hB0 + 8'(i), 1'b1);
        repeat (20) step();
        chk("auto beats", 32'(qb_d.size()), 32'd8);
        chk("no commit below PKT_SIZE", 32'(qa_d.size()), 32'd0);
        for (int i = 0; i < 8 && i < qb_d.size(); i++) begin
            chk($sformatf("auto data%0d", i), 32'(qb_d[i]), 32'(8'hB0 + 8'(i)));
            chk($sformatf("auto last%0d", i), 32'(qb_l[i]), 32'((i == 3) || (i == 7)));
        end
        if (qb_c.size() >= 5) begin
            chk("auto first beat cycle", 32'(qb_c[0]), 32'd5);
            chk("auto inter-packet gap", 32'(qb_c[4] - qb_c[3]), 32'd2);
        end

        // Fill EP6 to depth with the host stalled, then overrun
        do_reset();
        hir = 1'b0;
        for (int i = 0; i < 16; i++) wr(8'hC0 + 8'(i), 1'b1);
        settle();
        chk("full flagc", 32'(flagc_a), 32'h0);
        chk("full err_overrun before", 32'(eo_a), 32'h0);
        adv();
        wr(8'hEE, 1'b1);
        settle();
        chk("overrun flag", 32'(eo_a), 32'(ERR_EN));
        chk("overrun flagc", 32'(flagc_a), 32'h0);
        adv();
        clear_q();
        hir = 1'b1;
        repeat (24) step();
        chk("drain beats", 32'(qa_d.size()), 32'd16);
        for (int i = 0; i < 16 && i < qa_d.size(); i++) begin
            chk($sformatf("drain data%0d", i), 32'(qa_d[i]), 32'(8'hC0 + 8'(i)));
            chk($sformatf("drain last%0d", i), 32'(qa_l[i]), 32'(i == 15));
        end
        settle();
        chk("drained flagc", 32'(flagc_a), 32'h1);
        chk("drained host_in_valid", 32'(hiv_a), 32'h0);
        adv();

        // Reset with an open two-byte packet
        do_reset();
        hir = 1'b1;
        wr(8'hD0, 1'b1);
        wr(8'hD1, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("mid-reset host_in_valid", 32'(hiv_a), 32'h0);
        chk("mid-reset flagc", 32'(flagc_a), 32'h1);
        chk("mid-reset flagb", 32'(flagb_a), 32'h0);
        chk("mid-reset fdata_o", 32'(fdo_a), 32'h0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        clear_q();
        wr(8'hE0, 1'b1);
        wr(8'hE1, 1'b1);
        wr(8'hE2, 1'b0);
        repeat (10) step();
        chk("post-reset beats", 32'(qa_d.size()), 32'd3);
        for (int i = 0; i < 3 && i < qa_d.size(); i++) begin
            chk($sformatf("post-reset data%0d", i), 32'(qa_d[i]), 32'(8'hE0 + 8'(i)));
            chk($sformatf("post-reset last%0d", i), 32'(qa_l[i]), 32'(i == 2));
        end

        // Read from empty EP2: sticky underrun, cleared only by reset
        faddr = 2'b00; sloe = 1'b0; slrd = 1'b0;
        step();
        idle();
        settle();
        chk("underrun flag", 32'(eu_a), 32'(ERR_EN));
        chk("underrun flagb", 32'(flagb_a), 32'h0);
        adv();
        step();
        settle();
        chk("underrun sticky", 32'(eu_a), 32'(ERR_EN));
        adv();
        do_reset();
        settle();
        chk("reset clears underrun", 32'(eu_a), 32'h0);
        chk("reset clears overrun", 32'(eo_a), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fx2_slave_fifo_emu.md
# fx2_slave_fifo_emu

Synthesizable emulation of the FX2 USB2.0 chip side of the slave-FIFO interface. It responds to FIFOADR/SLRD/SLWR/SLOE/PKTEND from an FPGA-side slave-FIFO controller and drives FLAGB (EP2 OUT non-empty) and FLAGC (EP6 IN non-full). A host-side byte stream feeds EP2, and committed EP6 packets drain to the host side. It is used for board-level loopback and as the DUT partner in controller benches.

## Interface
- DATA_W, 8, bus width.
- EP_DEPTH, 512, bytes per endpoint buffer (power of 2).
- PKT_SIZE, 512, EP6 auto-commit size in bytes (≤ EP_DEPTH).
- LEN_DEPTH, 4, committed-packet length queue depth (power of 2).

Ports:
- fx2_ifclk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- fx2_faddr  in  2  00 = EP2 OUT, 10 = EP6 IN; 01/11 select nothing.
- fx2_sloe  in  1  output enable, active low.
- fx2_slrd  in  1  read strobe, active low.
- fx2_slwr  in  1  write strobe, active low.
- fx2_pkt_end  in  1  packet end, active low.
- fx2_fdata_i  in  DATA_W  write data from controller.
- fx2_fdata_o  out  DATA_W  read data to controller.
- fx2_flagb  out  1  1 = EP2 non-empty.
- fx2_flagc  out  1  1 = EP6 non-full.
- host_out_data/valid  in  DATA_W/1  host→EP2 stream.
- host_out_ready  out  1  EP2 not full.
- host_in_data  out  DATA_W  EP6→host stream.
- host_in_valid/host_in_last  out  1/1  last = final byte of packet.
- host_in_ready  in  1.
- err_underrun, err_overrun  out  1  sticky error flags.

## Operation
- EP2: host push on host_out_valid & host_out_ready. Pop at an edge with slrd=0, faddr=00 and EP2 non-empty. fx2_fdata_o = EP2 head (first-word fall-through) when sloe=0 & faddr=00, else 0.
- EP6: push fx2_fdata_i at an edge with slwr=0, faddr=10 and flagc=1.
- Assembler FSM P_EMPTY/P_OPEN, with open-byte counter cnt.
  - P_EMPTY→P_OPEN on first write.
  - Commit (push cnt to length queue, cnt←0, →P_EMPTY) when a write makes cnt=PKT_SIZE, or when pkt_end=0 & faddr=10 with cnt>0 after any same-edge write.
  - pkt_end with cnt=0 is ignored (no zero-length packets).
  - Write + pkt_end on the same edge: the byte is included, then the packet commits. Auto-commit and pkt_end on the same edge produce one packet.
- Drain FSM D_IDLE/D_BURST.
  - D_IDLE pops the length queue when non-empty, loads rem, then →D_BURST.
  - In D_BURST, host_in_valid=1 and host_in_last=(rem=1). Each handshake pops EP6 and decrements rem. Last handshake →D_IDLE.
- Flags:
  - flagb = EP2 occupancy ≠ 0.
  - flagc = (EP6 occupancy < EP_DEPTH) & length queue not full.
  - Both are combinational from registered counts, so they reflect the post-edge state with zero extra cycles.
- Errors (sticky until reset):
  - err_underrun: slrd=0 & faddr=00 with EP2 empty. The read is ignored.
  - err_overrun: slwr=0 & faddr=10 with flagc=0. The byte is dropped.
- Strobes with faddr ≠ their endpoint are ignored. Host push and controller pop on the same edge leave EP2 occupancy unchanged.
- Reset (including mid-packet): all buffers empty, open packet discarded, both FSMs idle.
- Reset output values: flagb=0, flagc=1, host_out_ready=1, host_in_valid=0, host_in_last=0, fx2_fdata_o=0, err flags=0.

## Timing
- Host push at edge N → flagb=1 after edge N.
- Controller pop of the last byte at edge N → flagb=0 after edge N. Back-to-back pops sustain 1 byte/cycle.
- EP6 commit at edge N → D_IDLE loads at edge N+1 → host_in_valid=1 after N+1.
- EP6 drain sustains 1 byte/cycle within a packet. There is 1 idle cycle between packets.

## Configuration
- FX2_EMU_ERR_EN defined: err_underrun and err_overrun are implemented as described.
- Not defined: both error outputs are tied 0 and no error logic is built.
- Data-path behaviour is identical either way.

## Structure
- Package fx2_emu_pkg holds:
  - FIFOADR constants EP2_ADDR=2'b00 and EP6_ADDR=2'b10.
  - Assembler and drain state encodings (one-hot).
- Sub-module fx2_sync_fifo: synchronous first-word fall-through FIFO with occupancy output. It is instantiated three times: EP2 data, EP6 data, and the length queue.

## Test plan
- 3 host bytes 0x11,0x22,0x33, then slrd/sloe low at faddr=00 for 3 cycles → fdata_o shows 0x11,0x22,0x33; flagb falls after the third edge; err_underrun stays 0.
- 5 writes 0xA0..0xA4 at faddr=10, pkt_end low on the 5th → one packet, 5 host_in beats with last on 0xA4, first valid 1 cycle after commit.
- PKT_SIZE=4, 8 consecutive writes, no pkt_end → two packets of 4, last on bytes 4 and 8.
- pkt_end pulses with no open bytes (controller idle pattern) → no packet and host_in_valid never rises.
- EP6 filled to EP_DEPTH with host_in_ready=0 → flagc=0; an extra write sets err_overrun and is dropped. Draining restores flagc=1.
- Reset asserted with 2 bytes in an open packet → host_in_valid=0, flagc=1, and the next packet contains only new bytes.
